// File: rtl/voice_pkg.sv
// Shared sizing constants for the voice allocator slice.
package voice_pkg;

    localparam int NUM_KEYS   = 24;
    localparam int NUM_VOICES = 4;
    localparam int KEY_W      = 5;
    localparam int AGE_W      = $clog2(NUM_VOICES) + 1;

endpackage

// File: rtl/prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest asserted request plus a valid flag.
module prio_enc #(
    parameter int W     = 4,
    parameter int IDX_W = 2
) (
    input  logic [W-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            idx   = req[i] ? IDX_W'(i) : idx;
            valid = valid | req[i];
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Assigns held keys to a small pool of tone-generator voices, stealing the oldest
// voice when the pool is exhausted; one allocation per clock edge.
module voice_allocator #(
    parameter int NUM_KEYS   = voice_pkg::NUM_KEYS,
    parameter int NUM_VOICES = voice_pkg::NUM_VOICES
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_KEYS-1:0]                  keys,
    output logic [NUM_VOICES-1:0]                voice_on,
    output logic [NUM_VOICES*voice_pkg::KEY_W-1:0] voice_key,
    output logic [NUM_VOICES-1:0]                note_on,
    output logic                                 busy
);
    import voice_pkg::*;

    localparam int VIDX_W = $clog2(NUM_VOICES);
    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

    logic [NUM_KEYS-1:0]   prev_r;
    logic [NUM_KEYS-1:0]   pending_r;
    logic [NUM_VOICES-1:0] voice_on_r;
    logic [NUM_VOICES-1:0] note_on_r;
    logic                  busy_r;
    logic [KEY_W-1:0]      voice_key_r [NUM_VOICES];
    logic [AGE_W-1:0]      age_r       [NUM_VOICES];

    logic [NUM_KEYS-1:0]   cand_vec_s;
    logic [KEY_W-1:0]      cand_idx_s;
    logic                  cand_valid_s;
    logic [NUM_VOICES-1:0] free_vec_s;
    logic [VIDX_W-1:0]     free_idx_s;
    logic                  free_valid_s;
    logic [VIDX_W-1:0]     old_idx_s;
    logic [AGE_W-1:0]      old_age_s;
    logic [VIDX_W-1:0]     tgt_s;
    logic [NUM_VOICES-1:0] rel_s;
    logic [NUM_VOICES-1:0] hit_s;
    logic [NUM_KEYS-1:0]   pend_next_s;
    logic [NUM_VOICES-1:0] voice_on_next_s;
    logic [KEY_W-1:0]      key_next_s [NUM_VOICES];
    logic [AGE_W-1:0]      age_next_s [NUM_VOICES];

    assign cand_vec_s = pending_r & keys;
    assign free_vec_s = ~voice_on_r;

    prio_enc #(.W(NUM_KEYS), .IDX_W(KEY_W)) u_key_enc (
        .req   (cand_vec_s),
        .idx   (cand_idx_s),
        .valid (cand_valid_s)
    );

    prio_enc #(.W(NUM_VOICES), .IDX_W(VIDX_W)) u_voice_enc (
        .req   (free_vec_s),
        .idx   (free_idx_s),
        .valid (free_valid_s)
    );

    // Oldest voice for stealing; strict compare keeps the lowest index on a tie.
    always_comb begin
        old_idx_s = '0;
        old_age_s = age_r[0];
        for (int v = 1; v < NUM_VOICES; v++) begin
            old_idx_s = (age_r[v] > old_age_s) ? VIDX_W'(v) : old_idx_s;
            old_age_s = (age_r[v] > old_age_s) ? age_r[v] : old_age_s;
        end
    end

    // Free/steal choice uses pre-edge occupancy, so a voice freed this edge waits one cycle.
    assign tgt_s = free_valid_s ? free_idx_s : old_idx_s;

    // Pending presses: new rising edges join, released keys and the winner leave.
    always_comb begin
        pend_next_s = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            pend_next_s[i] = keys[i] & (pending_r[i] | ~prev_r[i])
                           & ~(cand_valid_s && (cand_idx_s == KEY_W'(i)));
        end
    end

    // Per-voice next state: allocation overrides release, ages advance on each allocation.
    always_comb begin
        rel_s           = '0;
        hit_s           = '0;
        voice_on_next_s = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            rel_s[v]           = voice_on_r[v] & ~keys[voice_key_r[v]];
            hit_s[v]           = cand_valid_s && (tgt_s == VIDX_W'(v));
            voice_on_next_s[v] = hit_s[v] | (voice_on_r[v] & ~rel_s[v]);
            key_next_s[v]      = hit_s[v] ? cand_idx_s : voice_key_r[v];
            age_next_s[v]      = hit_s[v] ? '0 :
                                 ((cand_valid_s && voice_on_r[v] && (age_r[v] != AGE_MAX))
                                  ? age_r[v] + AGE_W'(1) : age_r[v]);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r     <= '0;
            pending_r  <= '0;
            voice_on_r <= '0;
            note_on_r  <= '0;
            busy_r     <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                voice_key_r[v] <= '0;
                age_r[v]       <= '0;
            end
        end else begin
            prev_r     <= keys;
            pending_r  <= pend_next_s;
            voice_on_r <= voice_on_next_s;
            note_on_r  <= hit_s;
            busy_r     <= |pend_next_s;
            for (int v = 0; v < NUM_VOICES; v++) begin
                voice_key_r[v] <= key_next_s[v];
                age_r[v]       <= age_next_s[v];
            end
        end
    end

    assign voice_on = voice_on_r;
    assign note_on  = note_on_r;
    assign busy     = busy_r;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_key_out
        assign voice_key[g*KEY_W +: KEY_W] = voice_key_r[g];
    end

endmodule
